// File: rtl/drbg_instantiate_ctrl.sv
// DRBG instantiate controller: validates a request, fetches entropy and
// nonce with timeout/retry, derives the initial seed and state bundle.
module drbg_instantiate_ctrl #(
   parameter int SEEDLEN          = 256,
   parameter int PERS_MAX_BYTES   = 32,
   parameter int HIGHEST_STRENGTH = 256,
   parameter bit PR_SUPPORTED     = 1'b1,
   parameter int TIMEOUT_CYC      = 64,
   parameter int MAX_RETRIES      = 3,
   parameter int CTR_W            = 48
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [8:0]         req_strength,
   input  logic               pred_res_req,
   input  logic [SEEDLEN-1:0] pers_str,
   input  logic [7:0]         pers_len,
   output logic               ent_req,
   input  logic               ent_valid,
   input  logic               ent_fail,
   input  logic [SEEDLEN-1:0] ent_data,
   output logic               nonce_req,
   input  logic               nonce_valid,
   input  logic [SEEDLEN-1:0] nonce_data,
   output logic               busy,
   output logic               done,
   output logic [1:0]         status,
   output logic               instantiated,
   output logic [8:0]         strength_out,
   output logic               pr_flag_out,
   output logic [SEEDLEN-1:0] seed_out,
   output logic [CTR_W-1:0]   reseed_ctr,
   output logic               catastrophic
);

   typedef enum logic [2:0] {
      IDLE, CHECK, ENT_WAIT, NONCE_WAIT, DERIVE, DONE
   } state_t;

   localparam int NB = SEEDLEN / 8;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int FW = $clog2(MAX_RETRIES + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_RETRIES - 1);
   localparam logic [8:0]    STR_MAX   = 9'(HIGHEST_STRENGTH);
   localparam logic [7:0]    PERS_MAX  = 8'(PERS_MAX_BYTES);

   state_t             state;
   logic [8:0]         strength_q;
   logic               pr_q;
   logic [SEEDLEN-1:0] pers_q;
   logic [7:0]         plen_q;
   logic [SEEDLEN-1:0] ent_q;
   logic [SEEDLEN-1:0] nonce_q;
   logic [TW-1:0]      tmo;
   logic [FW-1:0]      fails;
   logic [SEEDLEN-1:0] pers_masked;
   logic               chk_bad;
   logic [1:0]         chk_st;
   logic [8:0]         mapped;

   always_comb begin
      pers_masked = '0;
      for (int i = 0; i < NB; i++)
         if (i < int'(plen_q))
            pers_masked[i*8 +: 8] = pers_q[i*8 +: 8];
   end

   always_comb begin
      chk_bad = 1'b0;
      chk_st  = 2'b01;
      priority case (1'b1)
         catastrophic: begin
            chk_bad = 1'b1;
            chk_st  = 2'b10;
         end
         strength_q > STR_MAX,
         pr_q && !PR_SUPPORTED,
         plen_q > PERS_MAX: chk_bad = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      mapped = 9'd256;
      priority case (1'b1)
         strength_q <= 9'd112: mapped = 9'd112;
         strength_q <= 9'd128: mapped = 9'd128;
         strength_q <= 9'd192: mapped = 9'd192;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         strength_q   <= '0;
         pr_q         <= 1'b0;
         pers_q       <= '0;
         plen_q       <= '0;
         ent_q        <= '0;
         nonce_q      <= '0;
         tmo          <= '0;
         fails        <= '0;
         ent_req      <= 1'b0;
         nonce_req    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         status       <= 2'b00;
         instantiated <= 1'b0;
         strength_out <= '0;
         pr_flag_out  <= 1'b0;
         seed_out     <= '0;
         reseed_ctr   <= '0;
         catastrophic <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) begin
               strength_q   <= req_strength;
               pr_q         <= pred_res_req;
               pers_q       <= pers_str;
               plen_q       <= pers_len;
               instantiated <= 1'b0;
               seed_out     <= '0;
               strength_out <= '0;
               reseed_ctr   <= '0;
               pr_flag_out  <= 1'b0;
               busy         <= 1'b1;
               state        <= CHECK;
            end
            CHECK: if (chk_bad) begin
               status <= chk_st;
               done   <= 1'b1;
               state  <= DONE;
            end else begin
               strength_out <= mapped;
               tmo          <= '0;
               fails        <= '0;
               ent_req      <= 1'b1;
               state        <= ENT_WAIT;
            end
            // a valid response wins over a timeout in the same cycle
            ENT_WAIT: if (ent_valid && !ent_fail) begin
               ent_q     <= ent_data;
               ent_req   <= 1'b0;
               nonce_req <= 1'b1;
               tmo       <= '0;
               state     <= NONCE_WAIT;
            end else if (ent_valid || tmo == TMO_LAST) begin
               tmo   <= '0;
               fails <= fails + 1'b1;
               if (fails == FAIL_LAST) begin
                  ent_req      <= 1'b0;
                  catastrophic <= 1'b1;
                  status       <= 2'b10;
                  done         <= 1'b1;
                  state        <= DONE;
               end
            end else begin
               tmo <= tmo + 1'b1;
            end
            NONCE_WAIT: if (nonce_valid) begin
               nonce_q   <= nonce_data;
               nonce_req <= 1'b0;
               state     <= DERIVE;
            end else if (tmo == TMO_LAST) begin
               nonce_req    <= 1'b0;
               catastrophic <= 1'b1;
               status       <= 2'b10;
               done         <= 1'b1;
               state        <= DONE;
            end else begin
               tmo <= tmo + 1'b1;
            end
            DERIVE: begin
               seed_out     <= ent_q ^ nonce_q ^ pers_masked;
               reseed_ctr   <= CTR_W'(1);
               pr_flag_out  <= pr_q;
               instantiated <= 1'b1;
               status       <= 2'b00;
               done         <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/drbg_instantiate_ctrl.md
# drbg_instantiate_ctrl

Parametrised DRBG instantiate controller. On a `start` pulse it validates the request, maps the security strength, and fetches entropy and nonce over valid/request handshakes with timeout and retry. It then derives an initial seed and publishes a complete internal-state bundle to the downstream generate/reseed blocks. It reports success, error or catastrophic failure with a one-cycle `done` pulse.

## Interface
Parameters:
- `SEEDLEN`, 256: width of entropy, nonce, personalization and seed vectors; multiple of 8.
- `PERS_MAX_BYTES`, 32: maximum accepted personalization length in bytes; ≤ `SEEDLEN`/8.
- `HIGHEST_STRENGTH`, 256: highest supported strength; must be one of 112/128/192/256.
- `PR_SUPPORTED`, 1: prediction resistance is supported.
- `TIMEOUT_CYC`, 64: maximum wait cycles per entropy or nonce request attempt; ≥ 1.
- `MAX_RETRIES`, 3: number of failed entropy attempts that makes the failure catastrophic; ≥ 1.
- `CTR_W`, 48: reseed counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only in IDLE.
- `req_strength` in 9: requested strength in bits.
- `pred_res_req` in 1: prediction resistance requested.
- `pers_str` in `SEEDLEN`: personalization string; byte 0 = bits [7:0].
- `pers_len` in 8: personalization length in bytes.
- `ent_req` out 1: entropy request.
- `ent_valid` in 1: entropy response valid.
- `ent_fail` in 1: entropy source failure, qualified by `ent_valid`.
- `ent_data` in `SEEDLEN`: entropy input.
- `nonce_req` out 1: nonce request.
- `nonce_valid` in 1: nonce response valid.
- `nonce_data` in `SEEDLEN`: nonce.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: 00 success, 01 error, 10 catastrophic; valid when `done` is high and held afterwards.
- `instantiated` out 1: state bundle valid.
- `strength_out` out 9: mapped security strength.
- `pr_flag_out` out 1: prediction-resistance flag of the instance.
- `seed_out` out `SEEDLEN`: derived seed.
- `reseed_ctr` out `CTR_W`: initial reseed counter.
- `catastrophic` out 1: sticky failure flag.

## Operation
- States: IDLE, CHECK, ENT_WAIT, NONCE_WAIT, DERIVE, DONE.
- IDLE, `start` = 1:
  - Capture `req_strength`, `pred_res_req`, `pers_str`, `pers_len`.
  - Clear `instantiated`, `seed_out`, `strength_out`, `reseed_ctr`, `pr_flag_out`.
  - Go to CHECK.
- `start` in any other state is ignored.
- CHECK evaluates conditions in this priority order; the first match sends the FSM to DONE with the listed status:
  - `catastrophic` = 1: status 10.
  - `req_strength` > `HIGHEST_STRENGTH`: status 01.
  - `pred_res_req` = 1 and `PR_SUPPORTED` = 0: status 01.
  - `pers_len` > `PERS_MAX_BYTES`: status 01.
  - Otherwise: register the mapped strength and go to ENT_WAIT.
- Strength mapping: ≤112 → 112, ≤128 → 128, ≤192 → 192, otherwise → 256. A request of 0 maps to 112.
- ENT_WAIT:
  - `ent_req` = 1 continuously.
  - A cycle with `ent_valid` = 1 and `ent_fail` = 0 captures `ent_data` and goes to NONCE_WAIT.
  - A cycle with `ent_valid` = 1 and `ent_fail` = 1, or `TIMEOUT_CYC` cycles without `ent_valid`, is a failed attempt. The failure count increments and the timeout counter clears.
  - When the failure count reaches `MAX_RETRIES`, go to DONE with status 10 and set `catastrophic`.
- NONCE_WAIT:
  - `nonce_req` = 1.
  - `nonce_valid` captures `nonce_data` and goes to DERIVE.
  - `TIMEOUT_CYC` cycles without `nonce_valid` goes to DONE with status 10 and sets `catastrophic`.
- DERIVE:
  - `seed_out` = entropy ^ nonce ^ masked personalization, where pers bytes with index ≥ `pers_len` are zeroed.
  - `reseed_ctr` = 1.
  - `pr_flag_out` = captured `pred_res_req`.
  - `instantiated` = 1.
  - Go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- On status 01 or 10: `instantiated` = 0 and `seed_out` = 0.
- All result outputs hold until the next accepted `start` or reset.
- `catastrophic` is sticky; only `rst_n` clears it.

## Timing
- Reset (async assert, sync deassert) forces state IDLE and drives every output to 0: `busy`, `done`, `status`, `instantiated`, `strength_out`, `pr_flag_out`, `seed_out`, `reseed_ctr`, `catastrophic`, `ent_req`, `nonce_req`. The retry and timeout counters are also cleared.
- Reset mid-operation abandons the request with no `done` pulse.
- `start` is sampled in cycle 0. `busy` = 1 from cycle 1 until the cycle after `done`.
- Error or catastrophic detected in CHECK: `done` in cycle 2.
- Zero-wait success path:
  - Cycle 2: ENT_WAIT, `ent_valid` = 1.
  - Cycle 3: NONCE_WAIT, `nonce_valid` = 1.
  - Cycle 4: DERIVE.
  - Cycle 5: `done` with all result outputs valid.
- Each extra wait cycle adds one cycle of latency.
- `ent_req` and `nonce_req` drop in the cycle after the accepting edge.
- A timeout fires on the `TIMEOUT_CYC`-th wait cycle of an attempt.
- If `ent_valid` arrives in the same cycle the timeout fires, `ent_valid` wins.
- A `start` in the `done` cycle is ignored.

## Test plan
- `req_strength`=150, `pers_len`=4, entropy, nonce and pers all 0xFF..FF with zero-wait sources → `done` in cycle 5, `status`=00, `strength_out`=192, `reseed_ctr`=1, `seed_out` = 0x00..00FFFFFFFF in the low 4 bytes and 0 elsewhere.
- `req_strength`=300 → `done` in cycle 2, `status`=01, `instantiated`=0, `ent_req` never asserted.
- `PR_SUPPORTED`=0, `pred_res_req`=1 → `status`=01. Separately, `pers_len`=33 → `status`=01.
- `ent_fail` on 2 attempts, then good entropy, with `MAX_RETRIES`=3 → `status`=00.
- 3 failures → `status`=10, `catastrophic`=1; the next `start` → `status`=10 in cycle 2.
- Entropy silent for `TIMEOUT_CYC`×3 cycles → `status`=10.
- Nonce timeout → `status`=10.
- `rst_n` low during ENT_WAIT → all outputs 0, no `done`.
- `start` while busy → ignored.
